// File: rtl/la_rrarb_if.sv
// Request/grant bundle for la_rrarb: the requester side drives master, the arbiter uses slave.
interface la_rrarb_if #(
   parameter int unsigned N = 4
) ();
   localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

   logic           en;
   logic [N-1:0]   req;
   logic [N-1:0]   mask;
   logic           lock;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IdW-1:0] gnt_id;

   modport master (
      output en, req, mask, lock,
      input  gnt, gnt_valid, gnt_id
   );

   modport slave (
      input  en, req, mask, lock,
      output gnt, gnt_valid, gnt_id
   );
endinterface

// File: rtl/la_rrarb.sv
// Round-robin arbiter with registered, sticky, one-hot grants and a per-holder burst limit.
// Handover happens on the releasing edge, so the grant never bubbles through idle.
module la_rrarb #(
   parameter int unsigned N       = 4,
   parameter int unsigned MAXHOLD = 8,
   parameter string       PROP    = "DEFAULT"
) (
   input logic       clk,
   input logic       nreset,
   la_rrarb_if.slave bus
);
   localparam int unsigned     IdW    = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned     CntW   = (MAXHOLD == 0) ? 8 : $clog2(MAXHOLD + 1);
   localparam logic [CntW-1:0] CntMax = (MAXHOLD == 0) ? '1 : CntW'(MAXHOLD);

   typedef enum logic {StIdle, StGrant} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IdW-1:0]  id_q, id_d;
   logic [IdW-1:0]  ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [N-1:0]    qreq;
   logic [IdW-1:0]  ptr_rel;
   logic [IdW:0]    win_idle, win_rel;
   logic            rel;

   // Cyclic first-set search from start; MSB of the result flags a hit.
   function automatic logic [IdW:0] pick(input logic [N-1:0] q, input logic [IdW-1:0] start);
      logic [IdW:0] res;
      int unsigned  idx;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (32'(start) + 32'(i)) % N;
         if (q[idx]) res = {1'b1, idx[IdW-1:0]};
      end
      return res;
   endfunction

   always_comb begin
      qreq     = bus.req & ~bus.mask;
      ptr_rel  = (id_q == IdW'(N - 1)) ? '0 : id_q + 1'b1;
      win_idle = pick(qreq, ptr_q);
      win_rel  = pick(qreq, ptr_rel);
      rel      = !qreq[id_q]
               || ((MAXHOLD != 0) && (cnt_q == CntMax) && !bus.lock)
               || (!bus.en && !bus.lock);
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.en && win_idle[IdW]) begin
               state_d                = StGrant;
               id_d                   = win_idle[IdW-1:0];
               gnt_d                  = '0;
               gnt_d[win_idle[IdW-1:0]] = 1'b1;
               cnt_d                  = CntW'(1);
            end
         end
         StGrant: begin
            if (rel) begin
               ptr_d = ptr_rel;
               // Searching from holder+1 leaves the old holder last, so it re-wins only alone.
               if (bus.en && win_rel[IdW]) begin
                  id_d                    = win_rel[IdW-1:0];
                  gnt_d                   = '0;
                  gnt_d[win_rel[IdW-1:0]] = 1'b1;
                  cnt_d                   = CntW'(1);
               end else begin
                  state_d = StIdle;
                  id_d    = '0;
                  gnt_d   = '0;
                  cnt_d   = '0;
               end
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            id_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.gnt_id    = id_q;
endmodule

// File: tb/tb_la_rrarb.sv
// Self-checking bench for la_rrarb (N=4, MAXHOLD=2): vector table, directed corners,
// then random traffic against a queue-free behavioural model of the arbitration rules.
module tb_la_rrarb;
   localparam int N     = 4;
   localparam int MAXH  = 2;
   localparam int IdW   = 2;

   logic clk;
   logic nreset;
   int   n_checks;
   int   n_fail;

   la_rrarb_if #(.N(N)) bus ();

   la_rrarb #(.N(N), .MAXHOLD(MAXH), .PROP("DEFAULT")) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: holder index (-1 idle), rotation start and burst count.
   int m_holder;
   int m_ptr;
   int m_cnt;

   function automatic int find_from(input logic [N-1:0] q, input int start);
      for (int k = 0; k < N; k++) begin
         if (q[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] q;
      bit           done;
      int           w;
      q = bus.req & ~bus.mask;
      if (m_holder < 0) begin
         if (bus.en && q != 0) begin
            m_holder = find_from(q, m_ptr);
            m_cnt    = 1;
         end
      end else begin
         done = !q[m_holder] || (MAXH != 0 && m_cnt >= MAXH && !bus.lock)
             || (!bus.en && !bus.lock);
         if (done) begin
            m_ptr = (m_holder + 1) % N;
            w     = bus.en ? find_from(q, m_ptr) : -1;
            m_holder = w;
            m_cnt    = (w >= 0) ? 1 : 0;
         end else if (MAXH == 0 || m_cnt < MAXH) begin
            m_cnt = m_cnt + 1;
         end
      end
   endtask

   function automatic logic [N-1:0] m_gnt();
      logic [N-1:0] g;
      g = '0;
      if (m_holder >= 0) g[m_holder] = 1'b1;
      return g;
   endfunction

   function automatic logic [IdW-1:0] m_id();
      return (m_holder >= 0) ? IdW'(m_holder) : '0;
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [N-1:0] eg, input logic [IdW-1:0] eid);
      n_checks++;
      if (bus.gnt !== eg) begin
         n_fail++;
         $display("FAIL %s: gnt=%b expected %b at %0t", name, bus.gnt, eg, $time);
      end
      n_checks++;
      if (bus.gnt_valid !== (|eg)) begin
         n_fail++;
         $display("FAIL %s: gnt_valid=%b expected %b", name, bus.gnt_valid, |eg);
      end
      n_checks++;
      if (bus.gnt_id !== eid) begin
         n_fail++;
         $display("FAIL %s: gnt_id=%0d expected %0d", name, bus.gnt_id, eid);
      end
   endtask

   task automatic wait_gnt(input logic [N-1:0] target, input int budget, input string name);
      int k;
      k = 0;
      while (bus.gnt !== target && k < budget) begin
         step();
         k++;
      end
      n_checks++;
      if (bus.gnt !== target) begin
         n_fail++;
         $display("FAIL %s: gnt=%b never reached %b", name, bus.gnt, target);
      end
   endtask

   typedef struct {
      logic           en;
      logic [N-1:0]   req;
      logic [N-1:0]   mask;
      logic           lock;
      logic [N-1:0]   gnt;
      logic [IdW-1:0] id;
   } vec_t;

   vec_t         tbl [9];
   logic [N-1:0] fair_seq [9];
   logic [31:0]  r;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_reset();
      fair_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                   4'b1000, 4'b1000, 4'b0001};
      for (int i = 0; i < 9; i++) begin
         tbl[i].en   = 1'b1;
         tbl[i].req  = 4'hF;
         tbl[i].mask = 4'h0;
         tbl[i].lock = 1'b0;
         tbl[i].gnt  = fair_seq[i];
         tbl[i].id   = '0;
         for (int b = 0; b < N; b++) if (fair_seq[i][b]) tbl[i].id = IdW'(b);
      end

      // Reset held with every requester active.
      nreset   = 1'b0;
      bus.en   = 1'b1;
      bus.req  = 4'hF;
      bus.mask = 4'h0;
      bus.lock = 1'b0;
      #3;
      check("reset_hold", 4'b0000, 2'd0);
      @(posedge clk);
      #1;
      check("reset_edge", 4'b0000, 2'd0);
      #2;
      nreset = 1'b1;
      model_reset();

      // Fairness table; first entry is the first edge after reset release.
      for (int i = 0; i < 9; i++) begin
         bus.en   = tbl[i].en;
         bus.req  = tbl[i].req;
         bus.mask = tbl[i].mask;
         bus.lock = tbl[i].lock;
         step();
         check($sformatf("fair[%0d]", i), tbl[i].gnt, tbl[i].id);
      end

      // Lock keeps holder 2 well past the burst limit.
      wait_gnt(4'b0100, 8, "reach_holder2");
      bus.lock = 1'b1;
      for (int i = 0; i < 22; i++) begin
         step();
         check("lock_hold", 4'b0100, 2'd2);
      end
      bus.lock = 1'b0;
      step();
      check("lock_drop", 4'b1000, 2'd3);

      // Mask holder 1 mid-grant, then drop all requests.
      wait_gnt(4'b0010, 8, "reach_holder1");
      bus.mask = 4'b0010;
      step();
      check("mask_move", 4'b0100, 2'd2);
      bus.mask = 4'h0;
      bus.req  = 4'h0;
      step();
      check("drop_idle", 4'b0000, 2'd0);
      bus.req = 4'hF;
      step();
      check("ptr_after_drop", 4'b1000, 2'd3);

      // Enable low without lock releases; grant resumes from the advanced pointer.
      bus.en = 1'b0;
      step();
      check("en_off", 4'b0000, 2'd0);
      step();
      check("en_off_stay", 4'b0000, 2'd0);
      bus.en = 1'b1;
      step();
      check("en_on", 4'b0001, 2'd0);

      // Sole requester re-wins every burst without a gap.
      bus.req = 4'b1000;
      for (int i = 0; i < 9; i++) begin
         step();
         check("sole", 4'b1000, 2'd3);
      end
      #2;
      nreset = 1'b0;
      #1;
      check("async_reset", 4'b0000, 2'd0);
      nreset = 1'b1;
      model_reset();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         r        = $urandom;
         bus.req  = r[N-1:0];
         bus.mask = (r[7:6] == 2'b00) ? r[11:8] : 4'h0;
         bus.en   = (r[14:12] != 3'b000);
         bus.lock = (r[17:16] == 2'b00);
         if (i == 200) begin
            #2;
            nreset = 1'b0;
            #1;
            check("rand_reset", 4'b0000, 2'd0);
            nreset = 1'b1;
            model_reset();
         end
         step();
         check("rand", m_gnt(), m_id());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
